// File: rtl/dhvajanka_div_ctrl_16bit.sv
// Sequencing controller for the 16-bit Dhvajanka divider: operand handshake, divisor
// analysis window, 16-step restoring division and result handshake.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   IDLE    | in_ready high, waiting for an operand pair
//   ANALYZE | divisor driven to the analyzer; classification and fast path
//   DIVIDE  | one quotient bit per cycle, cnt 0..15
//   DONE    | out_valid high, results held until out_ready
module dhvajanka_div_ctrl_16bit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] dividend,
    input  logic [15:0] divisor,
    output logic [15:0] ana_divisor,
    input  logic        ana_is_near,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] quotient,
    output logic [15:0] remainder,
    output logic        div_by_zero,
    output logic        near_power10,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ANALYZE, DIVIDE, DONE} state_t;

    state_t      state, state_nxt;
    logic [15:0] quot_r, div_r, rem_r;
    logic [3:0]  cnt;
    logic [16:0] trial, trial_diff;
    logic        trial_ge;
    logic [15:0] rem_step, quot_step;
    logic        ana_exit;

    assign ana_divisor = div_r;
    assign busy        = (state != IDLE);
    // The analyzer path is external; its result is sampled on the second ANALYZE edge
    // so the freshly latched divisor has a full cycle to settle through it.
    assign ana_exit    = (cnt == 4'd1);

    always_comb begin
        trial      = {rem_r, quot_r[15]};
        trial_diff = trial - {1'b0, div_r};
        trial_ge   = (trial >= {1'b0, div_r});
        rem_step   = trial_ge ? trial_diff[15:0] : trial[15:0];
        quot_step  = {quot_r[14:0], trial_ge};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = ANALYZE;
            end
            ANALYZE: begin
                if (ana_exit) begin
                    if (div_r == 16'd0 || quot_r < div_r) state_nxt = DONE;
                    else                                  state_nxt = DIVIDE;
                end
            end
            DIVIDE: begin
                if (cnt == 4'd15) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quot_r       <= '0;
            div_r        <= '0;
            rem_r        <= '0;
            cnt          <= '0;
            quotient     <= '0;
            remainder    <= '0;
            div_by_zero  <= 1'b0;
            near_power10 <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        quot_r <= dividend;
                        div_r  <= divisor;
                        cnt    <= '0;
                    end
                end
                ANALYZE: begin
                    if (!ana_exit) begin
                        cnt <= 4'd1;
                    end else begin
                        near_power10 <= ana_is_near;
                        cnt          <= '0;
                        if (div_r == 16'd0) begin
                            quotient    <= 16'hFFFF;
                            remainder   <= quot_r;
                            div_by_zero <= 1'b1;
                        end else if (quot_r < div_r) begin
                            quotient  <= '0;
                            remainder <= quot_r;
                        end else begin
                            rem_r <= '0;
                        end
                    end
                end
                DIVIDE: begin
                    rem_r  <= rem_step;
                    quot_r <= quot_step;
                    cnt    <= cnt + 4'd1;
                    if (cnt == 4'd15) begin
                        quotient  <= quot_step;
                        remainder <= rem_step;
                    end
                end
                DONE: begin
                    if (out_ready) div_by_zero <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dhvajanka_div_ctrl_16bit.sv
// Bench for dhvajanka_div_ctrl_16bit: directed vector table, random pairs against
// integer division, backpressure and mid-operation reset sequences.
module tb_dhvajanka_div_ctrl_16bit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] dividend = '0;
    logic [15:0] divisor = '0;
    logic [15:0] ana_divisor;
    logic        ana_is_near;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;
    logic        near_power10;
    logic        busy;

    int n_checks = 0;
    int n_fail = 0;

    dhvajanka_div_ctrl_16bit dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor), .ana_divisor(ana_divisor),
        .ana_is_near(ana_is_near), .out_valid(out_valid), .out_ready(out_ready),
        .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero),
        .near_power10(near_power10), .busy(busy)
    );

    always #5 clk = ~clk;

    // Analyzer stand-in: within 1% of 1, 10, 100, 1000 or 10000.
    function automatic logic near_fn(input logic [15:0] d);
        int p = 1;
        int diff;
        for (int k = 0; k < 5; k++) begin
            diff = (int'(d) > p) ? int'(d) - p : p - int'(d);
            if (diff * 100 <= p) return 1'b1;
            p = p * 10;
        end
        return 1'b0;
    endfunction

    assign ana_is_near = near_fn(ana_divisor);

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] q;
        logic [15:0] r;
        logic        dbz;
        logic        near;
        int          lat;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Issues one operation with out_ready high; lat = edges from accept to out_valid.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          output logic [15:0] q, output logic [15:0] r,
                          output logic dbz, output logic nr, output int lat);
        @(negedge clk);
        dividend  = a;
        divisor   = b;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = -1;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = e;
                break;
            end
        end
        q   = quotient;
        r   = remainder;
        dbz = div_by_zero;
        nr  = near_power10;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] q, r, a, b, eq, er;
        logic        dbz, nr;
        int          lat;
        int          w;

        vecs[0]  = '{16'd1000,  16'd7,     16'd142,   16'd6,   1'b0, 1'b0, 18};
        vecs[1]  = '{16'd12345, 16'd10,    16'd1234,  16'd5,   1'b0, 1'b1, 18};
        vecs[2]  = '{16'd5,     16'd9,     16'd0,     16'd5,   1'b0, 1'b0, 2};
        vecs[3]  = '{16'd777,   16'd0,     16'hFFFF,  16'd777, 1'b1, 1'b0, 2};
        vecs[4]  = '{16'd65535, 16'd1,     16'd65535, 16'd0,   1'b0, 1'b1, 18};
        vecs[5]  = '{16'd65535, 16'd65535, 16'd1,     16'd0,   1'b0, 1'b0, 18};
        vecs[6]  = '{16'd100,   16'd3,     16'd33,    16'd1,   1'b0, 1'b0, 18};
        vecs[7]  = '{16'd1001,  16'd1000,  16'd1,     16'd1,   1'b0, 1'b1, 18};
        vecs[8]  = '{16'd999,   16'd1000,  16'd0,     16'd999, 1'b0, 1'b1, 2};
        vecs[9]  = '{16'd0,     16'd5,     16'd0,     16'd0,   1'b0, 1'b0, 2};
        vecs[10] = '{16'd40000, 16'd123,   16'd325,   16'd25,  1'b0, 1'b0, 18};

        #12;
        chk("rst in_ready", int'(in_ready), 1);
        chk("rst out_valid", int'(out_valid), 0);
        chk("rst busy", int'(busy), 0);
        chk("rst quotient", int'(quotient), 0);
        chk("rst remainder", int'(remainder), 0);
        chk("rst div_by_zero", int'(div_by_zero), 0);
        chk("rst near_power10", int'(near_power10), 0);
        chk("rst ana_divisor", int'(ana_divisor), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].a, vecs[i].b, q, r, dbz, nr, lat);
            chk($sformatf("vec%0d latency", i), lat, vecs[i].lat);
            chk($sformatf("vec%0d quotient", i), int'(q), int'(vecs[i].q));
            chk($sformatf("vec%0d remainder", i), int'(r), int'(vecs[i].r));
            chk($sformatf("vec%0d div_by_zero", i), int'(dbz), int'(vecs[i].dbz));
            chk($sformatf("vec%0d near_power10", i), int'(nr), int'(vecs[i].near));
            chk($sformatf("vec%0d in_ready after", i), int'(in_ready), 1);
        end

        for (int i = 0; i < 200; i++) begin
            a = 16'($urandom_range(0, 65535));
            b = (i % 4 == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom_range(0, 65535));
            if (b == 16'd0) begin
                eq = 16'hFFFF;
                er = a;
            end else begin
                eq = a / b;
                er = a % b;
            end
            run_op(a, b, q, r, dbz, nr, lat);
            chk($sformatf("rand %0d/%0d quotient", a, b), int'(q), int'(eq));
            chk($sformatf("rand %0d/%0d remainder", a, b), int'(r), int'(er));
        end

        // Backpressure with a stray in_valid pulse while busy.
        @(negedge clk);
        dividend  = 16'd1000;
        divisor   = 16'd7;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk("bp busy after accept", int'(busy), 1);
        @(negedge clk);
        dividend = 16'd5;
        divisor  = 16'd9;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 40) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk("bp out_valid rose", int'(out_valid), 1);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp hold%0d out_valid", c), int'(out_valid), 1);
            chk($sformatf("bp hold%0d quotient", c), int'(quotient), 142);
            chk($sformatf("bp hold%0d remainder", c), int'(remainder), 6);
            chk($sformatf("bp hold%0d in_ready", c), int'(in_ready), 0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp release out_valid", int'(out_valid), 0);
        chk("bp release in_ready", int'(in_ready), 1);
        repeat (3) @(posedge clk);
        #1;
        chk("bp no extra accept", int'(busy), 0);

        // Reset in the middle of DIVIDE (cnt=7) with a near-power-of-10 divisor captured.
        @(negedge clk);
        dividend = 16'd1001;
        divisor  = 16'd1000;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("mid busy", int'(busy), 1);
        chk("mid cnt", int'(dut.cnt), 7);
        rst_n = 1'b0;
        #1;
        chk("mid rst in_ready", int'(in_ready), 1);
        chk("mid rst out_valid", int'(out_valid), 0);
        chk("mid rst busy", int'(busy), 0);
        chk("mid rst quotient", int'(quotient), 0);
        chk("mid rst remainder", int'(remainder), 0);
        chk("mid rst near_power10", int'(near_power10), 0);
        chk("mid rst div_by_zero", int'(div_by_zero), 0);
        chk("mid rst ana_divisor", int'(ana_divisor), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(16'd100, 16'd3, q, r, dbz, nr, lat);
        chk("post rst latency", lat, 18);
        chk("post rst quotient", int'(q), 33);
        chk("post rst remainder", int'(r), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
